// File: rtl/epu_layer_scheduler_pkg.sv
// Shared definitions for the EPU layer scheduler: FSM state encoding,
// engine-id constants and the layer-descriptor field layout.
package epu_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_LAUNCH,
    ST_WAIT,
    ST_ADVANCE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ENG_CONV = 2'd0;
  localparam logic [1:0] ENG_POOL = 2'd1;
  localparam logic [1:0] ENG_NONE = 2'b11;

  localparam int LAYER_W = 5;
  localparam int TMO_W   = 16;

  // Descriptor word: [1:0] engine id, [2] swap ping-pong after layer,
  // [31:3] reserved.
  typedef struct packed {
    logic [28:0] rsvd;
    logic        swap;
    logic [1:0]  eng_id;
  } desc_t;

endpackage

// File: rtl/epu_layer_scheduler_if.sv
// Descriptor-SRAM and engine bus of the layer scheduler.
//   master : scheduler side (drives address/cs, engine starts, mux select, ping-pong)
//   slave  : SRAM/engine side (drives descriptor data and engine finish levels)
interface epu_layer_scheduler_if #(
  parameter int NUM_ENG = 3
);
  logic [4:0]         desc_addr;
  logic               desc_cs;
  logic [31:0]        desc_data;
  logic [NUM_ENG-1:0] eng_start;
  logic [NUM_ENG-1:0] eng_finish;
  logic [1:0]         eng_sel;
  logic               buf_swap;

  modport master (
    output desc_addr, desc_cs, eng_start, eng_sel, buf_swap,
    input  desc_data, eng_finish
  );

  modport slave (
    input  desc_addr, desc_cs, eng_start, eng_sel, buf_swap,
    output desc_data, eng_finish
  );
endinterface

// File: rtl/epu_layer_scheduler_tmo.sv
// epu_timeout_cnt: cycle counter for the engine-finish wait.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to zero (has priority over enable)
//   enable   : count one cycle
//   limit    : number of enabled cycles after which expired fires
//   expired  : high in the enabled cycle whose increment reaches limit
module epu_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + W'(1);
    cnt_d   = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_inc;
  end

  assign expired = enable && !clear && (cnt_inc == limit);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/epu_layer_scheduler.sv
// epu_layer_scheduler: walks a list of layer descriptors, launches the
// engine named by each one, waits for its finish (with timeout) and
// toggles the ping-pong buffer select between layers.
//   clk, rst          : clock, synchronous active-high reset
//   start, num_layers : run request (pulse) and layer count (1..31; 0 = empty run)
//   busy, done, error : status; done/error are one-cycle pulses
//   err_layer         : index of the layer that failed, held until next run
//   bus (master)      : descriptor SRAM, engine start/finish, eng_sel, buf_swap
module epu_layer_scheduler
  import epu_layer_scheduler_pkg::*;
#(
  parameter int         NUM_ENG = 3,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] num_layers,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LAYER_W-1:0] err_layer,
  epu_layer_scheduler_if.master bus
);
  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic [LAYER_W-1:0] num_layers_q, num_layers_d;
  logic [1:0]         eng_id_q, eng_id_d;
  logic               swap_q, swap_d;
  logic [1:0]         eng_sel_q, eng_sel_d;
  logic               buf_swap_q, buf_swap_d;
  logic [LAYER_W-1:0] err_layer_q, err_layer_d;
  logic               done_q, done_d;

  desc_t              desc_in;
  logic               unused_rsvd;
  logic               fin_sel;
  logic               tmo_expired;
  logic [NUM_ENG-1:0] eng_start_o;

  assign desc_in     = desc_t'(bus.desc_data);
  assign unused_rsvd = ^desc_in.rsvd;

  epu_timeout_cnt #(.W(TMO_W)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .limit   (TIMEOUT),
    .expired (tmo_expired)
  );

  // Only the finish line of the engine currently launched is observed.
  always_comb begin
    fin_sel = 1'b0;
    for (int i = 0; i < NUM_ENG; i++)
      if (int'(eng_id_q) == i) fin_sel = bus.eng_finish[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      layer_idx_q  <= '0;
      num_layers_q <= '0;
      eng_id_q     <= ENG_NONE;
      swap_q       <= 1'b0;
      eng_sel_q    <= ENG_NONE;
      buf_swap_q   <= 1'b0;
      err_layer_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_idx_q  <= layer_idx_d;
      num_layers_q <= num_layers_d;
      eng_id_q     <= eng_id_d;
      swap_q       <= swap_d;
      eng_sel_q    <= eng_sel_d;
      buf_swap_q   <= buf_swap_d;
      err_layer_q  <= err_layer_d;
      done_q       <= done_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    layer_idx_d  = layer_idx_q;
    num_layers_d = num_layers_q;
    eng_id_d     = eng_id_q;
    swap_d       = swap_q;
    eng_sel_d    = eng_sel_q;
    buf_swap_d   = buf_swap_q;
    err_layer_d  = err_layer_q;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_layers != '0) begin
            state_d      = ST_FETCH;
            layer_idx_d  = '0;
            num_layers_d = num_layers;
            buf_swap_d   = 1'b0;
            err_layer_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        eng_id_d = desc_in.eng_id;
        swap_d   = desc_in.swap;
        if (desc_in.eng_id == ENG_NONE || int'(desc_in.eng_id) >= NUM_ENG) begin
          state_d     = ST_ERROR;
          err_layer_d = layer_idx_q;
        end else begin
          state_d   = ST_LAUNCH;
          eng_sel_d = desc_in.eng_id;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // A finish arriving in the expiry cycle still counts as success.
        if (fin_sel) begin
          state_d = ST_ADVANCE;
        end else if (tmo_expired) begin
          state_d     = ST_ERROR;
          err_layer_d = layer_idx_q;
        end
      end
      ST_ADVANCE: begin
        eng_sel_d = ENG_NONE;
        if (swap_q) buf_swap_d = !buf_swap_q;
        if (layer_idx_q == num_layers_q - LAYER_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_FETCH;
          layer_idx_d = layer_idx_q + LAYER_W'(1);
        end
      end
      ST_ERROR: begin
        eng_sel_d = ENG_NONE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start_o = '0;
    if (state_q == ST_LAUNCH)
      for (int i = 0; i < NUM_ENG; i++)
        if (int'(eng_id_q) == i) eng_start_o[i] = 1'b1;
  end

  assign busy          = (state_q != ST_IDLE);
  assign error         = (state_q == ST_ERROR);
  assign done          = done_q;
  assign err_layer     = err_layer_q;
  assign bus.desc_cs   = (state_q == ST_FETCH);
  assign bus.desc_addr = layer_idx_q;
  assign bus.eng_start = eng_start_o;
  assign bus.eng_sel   = eng_sel_q;
  assign bus.buf_swap  = buf_swap_q;
endmodule

// File: tb/tb_epu_layer_scheduler.sv
// Scoreboard bench for epu_layer_scheduler: expected eng_start/done/error
// events (with their cycle stamp) are queued when a run is started and
// matched by a monitor as the DUT produces them.
module tb_epu_layer_scheduler;
  import epu_layer_scheduler_pkg::*;

  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] num_layers = '0;
  logic       busy, done, error;
  logic [4:0] err_layer;

  epu_layer_scheduler_if #(.NUM_ENG(3)) bus ();

  epu_layer_scheduler #(.NUM_ENG(3), .TIMEOUT(16'd20)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_layers (num_layers),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_layer  (err_layer),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int          cs_count = 0;
  ev_t         sb[$];
  logic [31:0] mem [32];
  logic [31:0] desc_drv = 32'hFFFF_FFFF;
  logic        cs_prev = 1'b0;
  logic [4:0]  addr_prev = '0;
  int          lat [3];
  int          cnt [3];
  bit          clr_pend [3];
  logic [2:0]  fin = '0;
  logic [2:0]  spur = '0;

  assign bus.desc_data  = desc_drv;
  assign bus.eng_finish = fin | spur;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev_start(input logic bs, input logic [1:0] id);
    logic [2:0] oh;
    oh = 3'b001 << id;
    return {26'd0, bs, id, oh};
  endfunction

  task automatic push(input int kind, input int c, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_match(input int kind, input logic [31:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_event_kind", kind, 0);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_cycle", cyc, e.cyc);
      check("sb_data", data, e.data);
    end
  endtask

  // Output monitor.
  always @(negedge clk) begin
    if (bus.desc_cs) cs_count++;
    if (bus.eng_start != '0) sb_match(EV_START, {26'd0, bus.buf_swap, bus.eng_sel, bus.eng_start});
    if (done)  sb_match(EV_DONE, 32'd0);
    if (error) sb_match(EV_ERR, 32'd0);
  end

  // Descriptor SRAM: data appears one cycle after the chip select.
  always @(negedge clk) begin
    if (rst) begin
      desc_drv = 32'hFFFF_FFFF;
      cs_prev  = 1'b0;
    end else begin
      desc_drv  = cs_prev ? mem[addr_prev] : 32'hFFFF_FFFF;
      cs_prev   = bus.desc_cs;
      addr_prev = bus.desc_addr;
    end
  end

  // Engines: finish level rises lat cycles into WAIT and stays high until
  // the first WAIT cycle of that engine's next launch.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i] = -1; fin[i] = 1'b0; clr_pend[i] = 1'b0;
      end else if (bus.eng_start[i]) begin
        cnt[i] = lat[i]; clr_pend[i] = 1'b1;
      end else begin
        if (clr_pend[i]) begin fin[i] = 1'b0; clr_pend[i] = 1'b0; end
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) fin[i] = 1'b1;
        end
      end
    end
  end

  task automatic begin_run(input logic [4:0] nl, output int s);
    @(negedge clk);
    start = 1'b1;
    num_layers = nl;
    s = cyc;
  endtask

  task automatic end_pulse();
    @(negedge clk);
    start = 1'b0;
    num_layers = 5'h1F;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check({tag, "_idle_within_budget"}, busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_error"},     error, 0);
    check({tag, "_err_layer"}, err_layer, 0);
    check({tag, "_desc_cs"},   bus.desc_cs, 0);
    check({tag, "_desc_addr"}, bus.desc_addr, 0);
    check({tag, "_eng_start"}, bus.eng_start, 0);
    check({tag, "_eng_sel"},   bus.eng_sel, ENG_NONE);
    check({tag, "_buf_swap"},  bus.buf_swap, 0);
  endtask

  initial begin
    int s;
    int cs0;
    for (int i = 0; i < 3; i++) lat[i] = 10;
    clear_mem();

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Three layers: conv(swap), pool(swap), conv; 10-cycle engines.
    clear_mem();
    mem[0] = {29'd0, 1'b1, ENG_CONV};
    mem[1] = {29'd0, 1'b1, ENG_POOL};
    mem[2] = {29'd0, 1'b0, ENG_CONV};
    cs0 = cs_count;
    begin_run(5'd3, s);
    push(EV_START, s + 3,  ev_start(1'b0, ENG_CONV));
    push(EV_START, s + 17, ev_start(1'b1, ENG_POOL));
    push(EV_START, s + 31, ev_start(1'b0, ENG_CONV));
    push(EV_DONE,  s + 43, 32'd0);
    end_pulse();
    check("run3_busy_after_start", busy, 1);
    wait_idle(100, "run3");
    check("run3_buf_swap_final", bus.buf_swap, 0);
    check("run3_desc_fetches", cs_count - cs0, 3);
    check("run3_eng_sel_released", bus.eng_sel, ENG_NONE);

    // Spurious pool finish while conv waits; swap leaves buf_swap at 1.
    clear_mem();
    mem[0] = {29'd0, 1'b1, ENG_CONV};
    begin_run(5'd1, s);
    push(EV_START, s + 3,  ev_start(1'b0, ENG_CONV));
    push(EV_DONE,  s + 15, 32'd0);
    end_pulse();
    wait_cyc(s + 4);
    spur = 3'b010;
    wait_idle(60, "spur");
    spur = 3'b000;
    check("spur_buf_swap_set", bus.buf_swap, 1);
    repeat (5) @(negedge clk);
    check("spur_buf_swap_held", bus.buf_swap, 1);

    // Engine never finishes: timeout of 20 wait cycles.
    clear_mem();
    mem[0] = {29'd0, 1'b0, ENG_CONV};
    lat[0] = -1;
    begin_run(5'd1, s);
    push(EV_START, s + 3,  ev_start(1'b0, ENG_CONV));
    push(EV_ERR,   s + 24, 32'd0);
    end_pulse();
    wait_idle(60, "tmo");
    check("tmo_err_layer", err_layer, 0);
    check("tmo_eng_sel", bus.eng_sel, ENG_NONE);
    lat[0] = 10;

    // Invalid engine id at layer 2 of 4.
    clear_mem();
    for (int i = 0; i < 3; i++) lat[i] = 3;
    mem[0] = {29'd0, 1'b0, ENG_CONV};
    mem[1] = {29'd0, 1'b0, ENG_POOL};
    mem[2] = {29'd0, 1'b0, ENG_NONE};
    mem[3] = {29'd0, 1'b0, ENG_CONV};
    cs0 = cs_count;
    begin_run(5'd4, s);
    push(EV_START, s + 3,  ev_start(1'b0, ENG_CONV));
    push(EV_START, s + 10, ev_start(1'b0, ENG_POOL));
    push(EV_ERR,   s + 17, 32'd0);
    end_pulse();
    wait_idle(60, "badid");
    check("badid_err_layer", err_layer, 2);
    check("badid_eng_sel", bus.eng_sel, ENG_NONE);
    check("badid_desc_fetches", cs_count - cs0, 3);
    for (int i = 0; i < 3; i++) lat[i] = 10;

    // Empty run.
    cs0 = cs_count;
    begin_run(5'd0, s);
    push(EV_DONE, s + 1, 32'd0);
    end_pulse();
    check("empty_busy", busy, 0);
    wait_idle(10, "empty");
    check("empty_desc_fetches", cs_count - cs0, 0);

    // Reset in WAIT of layer 1, after an ignored start while busy.
    clear_mem();
    mem[0] = {29'd0, 1'b1, ENG_CONV};
    mem[1] = {29'd0, 1'b0, ENG_CONV};
    mem[2] = {29'd0, 1'b0, ENG_CONV};
    begin_run(5'd3, s);
    push(EV_START, s + 3,  ev_start(1'b0, ENG_CONV));
    push(EV_START, s + 17, ev_start(1'b1, ENG_CONV));
    end_pulse();
    check("rstrun_err_layer_cleared", err_layer, 0);
    wait_cyc(s + 10);
    start = 1'b1;
    num_layers = 5'd5;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(s + 20);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_rst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrun_rst_sb_drained", sb.size(), 0);
    check("midrun_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end
endmodule
